// File: rtl/nibble_out_fifo.sv
// Show-ahead FIFO that queues processor output-port writes as {port, data} entries
// for a downstream consumer, with sticky overflow and illegal-port flags.
module nibble_out_fifo #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [1:0]               wr_port,
  input  logic [N-1:0]             wr_data,
  input  logic                     clr,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [1:0]               rd_port,
  output logic [N-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     bad_port
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [N+1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [N+1:0]  head;
  logic          wr_legal;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign rd_valid = !empty;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a write.
  assign wr_legal = wr_en && (wr_port != 2'd3);
  assign do_pop   = rd_valid && rd_ready;
  assign do_push  = wr_legal && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      bad_port <= 1'b0;
    end else if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      bad_port <= 1'b0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
      if (wr_legal && full && !do_pop) begin
        overflow <= 1'b1;
      end
      if (wr_en && (wr_port == 2'd3)) begin
        bad_port <= 1'b1;
      end
    end
  end

  // Storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (reset && !clr && do_push) begin
      mem[wptr] <= {wr_port, wr_data};
    end
  end

  assign head    = mem[rptr];
  assign rd_port = rd_valid ? head[N+1:N] : 2'd0;
  assign rd_data = rd_valid ? head[N-1:0] : '0;

endmodule

// File: tb/tb_nibble_out_fifo.sv
// Self-checking bench for nibble_out_fifo: a queue scoreboard models the FIFO contents
// and sticky flags, and every cycle compares the head, count and flags against it.
module tb_nibble_out_fifo;

  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic                   clk;
  logic                   reset;
  logic                   wr_en;
  logic [1:0]             wr_port;
  logic [N-1:0]           wr_data;
  logic                   clr;
  logic                   rd_ready;
  logic                   rd_valid;
  logic [1:0]             rd_port;
  logic [N-1:0]           rd_data;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   overflow;
  logic                   bad_port;

  logic [N+1:0] q[$];
  logic         m_ovf;
  logic         m_bad;
  int           vectors;
  int           miscompares;

  nibble_out_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_port(wr_port), .wr_data(wr_data),
    .clr(clr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_port(rd_port),
    .rd_data(rd_data), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .bad_port(bad_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_count"}, 32'(count), q.size());
    checkOutput({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
    checkOutput({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    checkOutput({tag, "_bad_port"}, 32'(bad_port), 32'(m_bad));
  endtask

  // Called at posedge+1; checks the head before the edge, updates the model, checks state after.
  task automatic applyStimulus(input logic we, input logic [1:0] wp, input logic [N-1:0] wd,
                               input logic rr, input logic cl);
    logic [N+1:0] hd;
    wr_en = we; wr_port = wp; wr_data = wd; rd_ready = rr; clr = cl;
    #1;
    checkOutput("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      hd = q[0];
      checkOutput("head_port", 32'(rd_port), 32'(hd[N+1:N]));
      checkOutput("head_data", 32'(rd_data), 32'(hd[N-1:0]));
    end else begin
      checkOutput("idle_bus", 32'({rd_port, rd_data}), 32'd0);
    end
    if (cl) begin
      q.delete();
      m_ovf = 1'b0;
      m_bad = 1'b0;
    end else begin
      if (rr && q.size() != 0) void'(q.pop_front());
      if (we && wp == 2'd3) m_bad = 1'b1;
      else if (we) begin
        if (q.size() < DEPTH) q.push_back({wp, wd});
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkState("post");
  endtask

  initial begin
    vectors = 0; miscompares = 0; m_ovf = 1'b0; m_bad = 1'b0;
    wr_en = 1'b0; wr_port = 2'd0; wr_data = '0; clr = 1'b0; rd_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    checkState("reset");
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_bus", 32'({rd_port, rd_data}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // three writes with the consumer stalled, then drain
    applyStimulus(1'b1, 2'd0, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 4'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);

    // overfill by one, then drain
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 2'(i % 3), 4'(i + 1), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);

    // full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'(i % 3), 4'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 2'(i % 3), 4'(i + 8), 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);

    // illegal port, then flush with a competing write
    applyStimulus(1'b1, 2'd1, 4'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 4'd6, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);

    // asynchronous reset between edges with five entries held
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd1, 4'(i + 3), 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_bad = 1'b0;
    checkState("async_reset");
    checkOutput("async_rd_valid", 32'(rd_valid), 32'd0);
    wr_en = 1'b1; wr_port = 2'd0; wr_data = 4'd9; rd_ready = 1'b1;
    @(posedge clk); #1;
    checkState("held_reset");
    wr_en = 1'b0; rd_ready = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 2'd2, 4'd11, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);

    // random mixed traffic
    for (int i = 0; i < 150; i++)
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_out_fifo.md
NIBBLE_OUT_FIFO -- requirements
Module: nibble_out_fifo

Interface
REQ-001 SHALL have parameter N, default 4: data width of a processor I/O port.
REQ-002 SHALL have parameter DEPTH, default 8, power of two, 2..16: FIFO entries.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port wr_en, input, 1: processor output-port write strobe, one entry per cycle high.
REQ-006 SHALL have port wr_port, input, 2: target port; 0=Out0, 1=Out1, 2=Out2, 3=illegal.
REQ-007 SHALL have port wr_data, input, N: value written to the port.
REQ-008 SHALL have port clr, input, 1: synchronous flush of entries and sticky flags.
REQ-009 SHALL have port rd_ready, input, 1: downstream consumer accepts the head entry.
REQ-010 SHALL have port rd_valid, output, 1: head entry present.
REQ-011 SHALL have port rd_port, output, 2: port tag of the head entry.
REQ-012 SHALL have port rd_data, output, N: data of the head entry.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1: entries held, 0..DEPTH.
REQ-014 SHALL have ports full and empty, output, 1 each: count==DEPTH and count==0.
REQ-015 SHALL have port overflow, output, 1: sticky; a legal write was dropped.
REQ-016 SHALL have port bad_port, output, 1: sticky; a write with wr_port==3 was seen.

Function
REQ-017 SHALL store {wr_port, wr_data} in arrival order and return entries strictly in FIFO order.
REQ-018 SHALL be show-ahead: rd_valid = !empty; rd_port and rd_data drive the head entry combinationally from storage.
REQ-019 SHALL push on a rising edge when wr_en=1, wr_port!=3, and (!full or pop in the same cycle).
REQ-020 SHALL pop on a rising edge when rd_valid=1 and rd_ready=1.
REQ-021 SHALL assert rd_valid for a write into an empty FIFO in the cycle after the push edge; no bypass path from wr_data to rd_data.
REQ-022 SHALL, on simultaneous push and pop, leave count unchanged, including when full.
REQ-023 SHALL, when empty with wr_en=1 and rd_ready=1, push only; count becomes 1 and no pop occurs.
REQ-024 SHALL wrap read and write pointers modulo DEPTH with no loss or duplication of entries.
REQ-025 SHALL drop a legal write when full without a pop in the same cycle, set overflow=1, and leave storage, pointers and count unchanged.
REQ-026 SHALL ignore a write with wr_port==3, set bad_port=1, and leave storage and count unchanged.
REQ-027 SHALL hold overflow and bad_port at 1 until clr or reset.
REQ-028 SHALL, on clr=1 at an edge, zero pointers, count, overflow and bad_port; clr overrides push and pop in that cycle.
REQ-029 SHALL hold rd_port and rd_data stable while rd_valid=1 and rd_ready=0.
REQ-030 SHALL treat rd_ready as don't-care while empty; it has no effect on state.

Reset
REQ-031 SHALL, while reset=0, immediately force count=0, empty=1, full=0, rd_valid=0, overflow=0, bad_port=0, and pointers to 0, independent of clk.
REQ-032 SHALL drive rd_port=0 and rd_data=0 while empty, so the bus is 0 after reset.
REQ-033 SHALL discard all stored entries on reset asserted mid-operation; storage contents need not be cleared.
REQ-034 SHALL accept neither push nor pop on the first rising edge at which reset is sampled low; operation resumes on the first edge after reset=1.

Verification
REQ-035 Reset then three writes (port0,2),(port1,3),(port2,4), rd_ready=0 -> count=3; rd_valid=1 one cycle after the first write; head stays {0,2}.
REQ-036 Drain with rd_ready=1 -> {0,2},{1,3},{2,4} on consecutive cycles; then empty=1, rd_data=0.
REQ-037 Write 9 legal entries with rd_ready=0 (DEPTH=8) -> full=1 after the 8th; 9th dropped, overflow=1, count=8; drain returns the first 8 in order.
REQ-038 When full, hold wr_en=1 and rd_ready=1 for 20 cycles with incrementing data -> count stays 8; output sequence continuous across pointer wrap; overflow not set.
REQ-039 Write with wr_port=3, data 5 -> bad_port=1, count unchanged; then clr=1 for one cycle -> count=0, bad_port=0, overflow=0.
REQ-040 Drop reset to 0 between clock edges with count=5 -> count=0, rd_valid=0 with no clock edge; after release, one write is visible one cycle later.
